// File: rtl/ahb_slave_port.sv
// AHB-Lite responder: turns each accepted bus transfer into one req/ack backend
// transaction, stalling the data phase until ack, backend error, timeout or an illegal access.
module ahb_slave_port #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              bk_req,
  output logic              bk_write,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [2:0]        bk_size,
  output logic [DATA_W-1:0] bk_wdata,
  input  logic              bk_ack,
  input  logic [DATA_W-1:0] bk_rdata,
  input  logic              bk_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              bk_req_q, bk_req_d;
  logic              bk_write_q, bk_write_d;
  logic [ADDR_W-1:0] bk_addr_q, bk_addr_d;
  logic [2:0]        bk_size_q, bk_size_d;

  logic accept;
  logic legal;
  logic unused_htrans;

  // SEQ and NONSEQ are treated alike, so only HTRANS[1] matters.
  assign unused_htrans = HTRANS[0];
  assign accept        = HSEL && HTRANS[1] && HREADY;

  always_comb begin
    legal = 1'b1;
    if (HSIZE > 3'b010) begin
      legal = 1'b0;
    end else if ((HSIZE == 3'b001) && HADDR[0]) begin
      legal = 1'b0;
    end else if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hrdata_d   = hrdata_q;
    bk_write_d = bk_write_q;
    bk_addr_d  = bk_addr_q;
    bk_size_d  = bk_size_q;

    case (state_q)
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bk_ack) begin
          if (bk_err) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_RESP;
            if (!bk_write_q) begin
              hrdata_d = bk_rdata;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        // IDLE, RESP and ERR2 all end a data phase and may take the next address phase.
        if (accept) begin
          bk_write_d = HWRITE;
          bk_addr_d  = HADDR;
          bk_size_d  = HSIZE;
          if (legal) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            state_d = S_ERR1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    hreadyout_d = !((state_d == S_DATA) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    bk_req_d    = (state_d == S_DATA);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      bk_req_q    <= 1'b0;
      bk_write_q  <= 1'b0;
      bk_addr_q   <= '0;
      bk_size_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      bk_req_q    <= bk_req_d;
      bk_write_q  <= bk_write_d;
      bk_addr_q   <= bk_addr_d;
      bk_size_q   <= bk_size_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign bk_req    = bk_req_q;
  assign bk_write  = bk_write_q;
  assign bk_addr   = bk_addr_q;
  assign bk_size   = bk_size_q;
  // The master holds HWDATA for the whole data phase, so no capture is needed.
  assign bk_wdata  = HWDATA;

endmodule

// File: tb/tb_ahb_slave_port.sv
// Randomized bench for ahb_slave_port: transfer-level model feeds a scoreboard queue,
// a negedge monitor checks each data phase, and a backend responder answers bk_req.
module tb_ahb_slave_port;

  localparam int TIMEOUT = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        bk_req;
  logic        bk_write;
  logic [31:0] bk_addr;
  logic [2:0]  bk_size;
  logic [31:0] bk_wdata;
  logic        bk_ack;
  logic [31:0] bk_rdata;
  logic        bk_err;

  assign HREADY = HREADYOUT;

  ahb_slave_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .bk_req(bk_req), .bk_write(bk_write), .bk_addr(bk_addr), .bk_size(bk_size),
    .bk_wdata(bk_wdata), .bk_ack(bk_ack), .bk_rdata(bk_rdata), .bk_err(bk_err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    bit          is_err;
    int          waits;
    int          req_cycles;
    logic [31:0] rdata;
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    int          lat;
    bit          err;
    bit          noack;
    logic [31:0] data;
  } bk_t;

  exp_t        sq[$];
  bk_t         bq[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  bit          stray_ack = 1'b0;
  bit          in_phase = 1'b0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Backend responder: acks k cycles into each bk_req burst as scripted by the model.
  initial begin
    bk_t cur_b;
    bit  active;
    int  k;
    active = 1'b0;
    k = 0;
    cur_b = '{lat: 0, err: 1'b0, noack: 1'b1, data: 32'h0};
    bk_ack = 1'b0;
    bk_err = 1'b0;
    bk_rdata = 32'h0;
    forever begin
      @(posedge HCLK);
      #1;
      bk_ack = 1'b0;
      bk_err = 1'($urandom % 2);
      bk_rdata = $urandom;
      if (stray_ack) begin
        bk_ack = 1'b1;
      end else if (bk_req) begin
        if (!active) begin
          active = 1'b1;
          k = 0;
          if (bq.size() > 0) cur_b = bq.pop_front();
          else cur_b = '{lat: 0, err: 1'b0, noack: 1'b1, data: 32'h0};
        end else begin
          k++;
        end
        if (!cur_b.noack && k == cur_b.lat) begin
          bk_ack = 1'b1;
          bk_err = cur_b.err;
          bk_rdata = cur_b.data;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // Monitor: follows each accepted transfer through its data phase.
  initial begin
    exp_t        cur;
    int          waits;
    int          req_cnt;
    int          resp_hi;
    logic        last_lo_resp;
    logic [31:0] mon_rd;
    waits = 0;
    req_cnt = 0;
    resp_hi = 0;
    last_lo_resp = 1'b0;
    mon_rd = 32'h0;
    cur = '{is_err: 1'b0, waits: 0, req_cycles: 0, rdata: 32'h0, addr: 32'h0,
            wr: 1'b0, size: 3'h0, wdata: 32'h0};
    forever begin
      @(negedge HCLK);
      if (!mon_en) begin
        in_phase = 1'b0;
        mon_rd = 32'h0;
      end else begin
        if (in_phase) begin
          if (bk_req) begin
            req_cnt++;
            chk("bk_addr", bk_addr, cur.addr);
            chk("bk_write", 32'(bk_write), 32'(cur.wr));
            chk("bk_size", 32'(bk_size), 32'(cur.size));
            if (cur.wr) chk("bk_wdata", bk_wdata, cur.wdata);
          end
          if (!HREADYOUT) begin
            waits++;
            if (HRESP) resp_hi++;
            last_lo_resp = HRESP;
            if (waits > TIMEOUT + 8) begin
              chk("phase_overrun", 32'(waits), 32'(cur.waits));
              in_phase = 1'b0;
            end
          end else begin
            chk("hresp", 32'(HRESP), 32'(cur.is_err));
            chk("wait_states", 32'(waits), 32'(cur.waits));
            chk("bk_req_cycles", 32'(req_cnt), 32'(cur.req_cycles));
            chk("err1_resp_cycles", 32'(resp_hi), cur.is_err ? 32'd1 : 32'd0);
            if (cur.is_err) chk("err1_last_resp", 32'(last_lo_resp), 32'd1);
            chk("hrdata", HRDATA, cur.rdata);
            mon_rd = cur.rdata;
            in_phase = 1'b0;
          end
        end else begin
          chk("idle_ready_resp_req", 32'({HREADYOUT, HRESP, bk_req}), 32'h4);
          chk("idle_hrdata", HRDATA, mon_rd);
        end
        if (HSEL && HTRANS[1] && HREADYOUT) begin
          if (sq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_accept actual=accept required=none at %0t", $time);
          end else begin
            cur = sq.pop_front();
            in_phase = 1'b1;
            waits = 0;
            req_cnt = 0;
            resp_hi = 0;
            last_lo_resp = 1'b0;
          end
        end
      end
    end
  end

  task automatic drive_accept(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input logic [31:0] wd);
    int n;
    n = 0;
    HSEL = 1'b1;
    HTRANS = ($urandom % 2) ? 2'b10 : 2'b11;
    HADDR = a;
    HWRITE = w;
    HSIZE = sz;
    forever begin
      @(negedge HCLK);
      if (HREADYOUT) break;
      n++;
      if (n > 100) begin
        failures++;
        $display("FAIL accept_wait actual=stalled required=HREADYOUT checks=%0d", checks);
        $fatal(1, "slave never became ready");
      end
    end
    @(posedge HCLK);
    #1;
    HWDATA = wd;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HADDR = $urandom;
  endtask

  // Transfer-level model: legality, backend latency and error decide the whole response.
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                       input logic [31:0] wd, input int lat, input bit err,
                       input bit noack, input logic [31:0] rd);
    exp_t e;
    bit   legal;
    bit   tmo;
    legal = (sz <= 3'd2) && !(sz == 3'd1 && a[0]) && !(sz == 3'd2 && a[1:0] != 2'b00);
    tmo = noack || (lat >= TIMEOUT);
    e.addr = a;
    e.wr = w;
    e.size = sz;
    e.wdata = wd;
    if (!legal) begin
      e.is_err = 1'b1;
      e.waits = 1;
      e.req_cycles = 0;
    end else begin
      bq.push_back('{lat: lat, err: err, noack: tmo, data: rd});
      if (tmo) begin
        e.is_err = 1'b1;
        e.waits = TIMEOUT + 1;
        e.req_cycles = TIMEOUT;
      end else begin
        e.is_err = err;
        e.waits = lat + 1 + (err ? 1 : 0);
        e.req_cycles = lat + 1;
        if (!err && !w) last_rd = rd;
      end
    end
    e.rdata = last_rd;
    sq.push_back(e);
    drive_accept(a, w, sz, wd);
  endtask

  task automatic idle_cycle();
    HSEL = 1'($urandom % 2);
    HTRANS = HSEL ? {1'b0, 1'($urandom % 2)} : 2'($urandom % 4);
    HADDR = $urandom;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    HSEL = 1'b0;
    HTRANS = 2'b00;
    while ((sq.size() != 0 || in_phase) && n < 200) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL drain actual=pending%0d required=0", sq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          lat;
    bit          err;
    bit          noack;
    HRESET = 1'b1;
    HSEL = 1'b0;
    HADDR = 32'h0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE = 3'h0;
    HWDATA = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_bk_req", 32'(bk_req), 32'd0);
    chk("rst_bk_addr", bk_addr, 32'h0);
    chk("rst_bk_write_size", 32'({bk_write, bk_size}), 32'h0);
    mon_en = 1'b1;
    @(posedge HCLK);
    #1;
    repeat (2) idle_cycle();

    issue(32'h10, 1'b1, 3'd2, 32'hA5A5_0001, 1, 1'b0, 1'b0, 32'h0);
    idle_cycle();
    issue(32'h20, 1'b0, 3'd2, 32'h0, 0, 1'b0, 1'b0, 32'h1111_2222);
    issue(32'h24, 1'b0, 3'd2, 32'h0, 0, 1'b0, 1'b0, 32'h3333_4444);
    idle_cycle();
    issue(32'h30, 1'b0, 3'd2, 32'h0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    issue(32'h02, 1'b1, 3'd2, 32'h5555_0002, 0, 1'b0, 1'b0, 32'h0);
    issue(32'h40, 1'b1, 3'd3, 32'h5555_0040, 0, 1'b0, 1'b0, 32'h0);
    issue(32'h44, 1'b0, 3'd2, 32'h0, 0, 1'b0, 1'b1, 32'h0);
    issue(32'h46, 1'b0, 3'd1, 32'h0, 2, 1'b0, 1'b0, 32'h0BAD_F00D);
    issue(32'h47, 1'b0, 3'd0, 32'h0, TIMEOUT - 1, 1'b0, 1'b0, 32'h7777_0001);

    for (int i = 0; i < 150; i++) begin
      a = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0} | 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      noack = (r == 8);
      lat = (r < 6) ? $urandom_range(0, 3) : $urandom_range(4, TIMEOUT - 1);
      err = ($urandom_range(0, 7) == 0);
      issue(a, 1'($urandom % 2), 3'($urandom_range(0, 3)), $urandom, lat, err, noack, $urandom);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) idle_cycle();
    end
    wait_drain();

    // Reset in the 5th DATA cycle of a transfer the backend never answers.
    mon_en = 1'b0;
    bq.push_back('{lat: 0, err: 1'b0, noack: 1'b1, data: 32'h0});
    drive_accept(32'h50, 1'b0, 3'd2, 32'h0);
    repeat (4) begin
      @(posedge HCLK);
      #1;
    end
    chk("pre_reset_bk_req", 32'(bk_req), 32'd1);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("midrst_bk_req", 32'(bk_req), 32'd0);
    chk("midrst_ready_resp", 32'({HREADYOUT, HRESP}), 32'h2);
    chk("midrst_hrdata", HRDATA, 32'h0);
    stray_ack = 1'b1;
    @(negedge HCLK);
    stray_ack = 1'b0;
    @(negedge HCLK);
    chk("stray_ack_ready_resp_req", 32'({HREADYOUT, HRESP, bk_req}), 32'h4);
    chk("stray_ack_hrdata", HRDATA, 32'h0);
    last_rd = 32'h0;
    mon_en = 1'b1;
    @(posedge HCLK);
    #1;
    issue(32'h60, 1'b1, 3'd2, 32'hCAFE_0060, 0, 1'b0, 1'b0, 32'h0);
    issue(32'h64, 1'b0, 3'd2, 32'h0, 3, 1'b0, 1'b0, 32'h1234_5678);
    wait_drain();
    repeat (2) @(posedge HCLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
